// File: rtl/rng_axi_pkg.sv
// rtl/rng_axi_pkg.sv - shared AXI codes, RNG slave register map and fetch FSM states
package rng_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] RNG_DATA   = 32'h0000_0000;
  localparam logic [31:0] CONTROL    = 32'h0000_0004;
  localparam logic [31:0] SEED       = 32'h0000_0008;
  localparam logic [31:0] READ_COUNT = 32'h0000_000C;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [3:0] LEN_SINGLE = 4'h0;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } fetch_state_t;

  // Debug counters stick at all-ones rather than wrapping back to zero.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/rng_word_fifo.sv
// rtl/rng_word_fifo.sv - synchronous word FIFO with occupancy level
module rng_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;

  // Head entry is read straight from storage, so a word is visible the cycle after its push.
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/rng_fetch_master.sv
// rtl/rng_fetch_master.sv - AXI read master polling the RNG data register into a word stream
module rng_fetch_master
  import rng_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h6400_0000,
  parameter logic [15:0] AXI_ID     = 16'h0010,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        enable,
  output logic [15:0] ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [15:0] RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] err_count,
  output logic [15:0] stuck_count,
  output logic [4:0]  fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t state;
  logic [31:0]  last_word;
  logic         have_last;
  logic         r_fire;
  logic         beat_ok;
  logic         push;
  logic         fifo_empty;
  logic         fifo_full;
  logic [LW-1:0] level;

  assign ARID    = AXI_ID;
  assign ARADDR  = BASE_ADDR + RNG_DATA;
  assign ARLEN   = LEN_SINGLE;
  assign ARSIZE  = SIZE_4B;
  assign ARBURST = BURST_INCR;

  assign r_fire  = (state == DATA) && RVALID && RREADY;
  assign beat_ok = (RRESP == RESP_OKAY) && (RID == AXI_ID) && RLAST;
  assign push    = r_fire && beat_ok;

  // A single outstanding read means the slot seen free in IDLE is still free on return.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state       <= IDLE;
      ARVALID     <= 1'b0;
      RREADY      <= 1'b0;
      err_count   <= '0;
      stuck_count <= '0;
      last_word   <= '0;
      have_last   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && !fifo_full) begin
            ARVALID <= 1'b1;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (ARVALID && ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          if (r_fire) begin
            RREADY <= 1'b0;
            state  <= IDLE;
            if (beat_ok) begin
              if (have_last && (RDATA == last_word)) begin
                stuck_count <= sat_inc(stuck_count);
              end
              last_word <= RDATA;
              have_last <= 1'b1;
            end else begin
              err_count <= sat_inc(err_count);
            end
          end
        end
        default: begin
          ARVALID <= 1'b0;
          RREADY  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  rng_word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (push),
    .wdata (RDATA),
    .pop   (m_valid && m_ready),
    .rdata (m_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );

  assign m_valid    = !fifo_empty;
  assign fifo_level = 5'(level);

endmodule

// File: tb/tb_rng_fetch_master.sv
// tb/tb_rng_fetch_master.sv - scoreboard bench with a behavioural RNG slave
module tb_rng_fetch_master;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic [15:0] id;
    logic        last;
    int          hold;
  } beat_t;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY = 1'b0;
  logic [15:0] RID = 16'h0;
  logic [31:0] RDATA = 32'h0;
  logic [1:0]  RRESP = 2'b00;
  logic        RLAST = 1'b0;
  logic        RVALID = 1'b0;
  logic        RREADY;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] err_count;
  logic [15:0] stuck_count;
  logic [4:0]  fifo_level;

  int n_checks = 0;
  int n_fail = 0;
  int read_count = 0;
  bit rand_err = 1'b0;

  beat_t       plan_q[$];
  beat_t       beat_q[$];
  logic [31:0] exp_q[$];

  rng_fetch_master dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .enable      (enable),
    .ARID        (ARID),
    .ARADDR      (ARADDR),
    .ARLEN       (ARLEN),
    .ARSIZE      (ARSIZE),
    .ARBURST     (ARBURST),
    .ARVALID     (ARVALID),
    .ARREADY     (ARREADY),
    .RID         (RID),
    .RDATA       (RDATA),
    .RRESP       (RRESP),
    .RLAST       (RLAST),
    .RVALID      (RVALID),
    .RREADY      (RREADY),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .err_count   (err_count),
    .stuck_count (stuck_count),
    .fifo_level  (fifo_level)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural slave: drives on falling edges, replays planned beats, else random words.
  initial begin : slave
    bit          pend = 1'b0;
    bit          ar_seen = 1'b0;
    int          ar_cnt = 0;
    int          hold_cur = 0;
    int          r_delay = 0;
    logic [31:0] prev_data = 32'h0;
    beat_t       b;
    forever begin
      @(negedge ACLK);
      ARREADY = 1'b0;
      RVALID  = 1'b0;
      if (ARESET) begin
        pend    = 1'b0;
        ar_seen = 1'b0;
      end else if (pend) begin
        if (r_delay > 0) begin
          r_delay--;
        end else if (RREADY) begin
          if (plan_q.size() > 0) begin
            b = plan_q.pop_front();
          end else begin
            b.data = $urandom;
            b.resp = 2'b00;
            b.id   = 16'h0010;
            b.last = 1'b1;
            b.hold = 0;
            if (rand_err) begin
              case ($urandom_range(0, 15))
                0: b.resp = 2'b10;
                1: b.id   = 16'h0011;
                2: b.last = 1'b0;
                3: b.data = prev_data;
                4: b.resp = 2'b01;
                default: ;
              endcase
            end
          end
          prev_data = b.data;
          RDATA  = b.data;
          RRESP  = b.resp;
          RID    = b.id;
          RLAST  = b.last;
          RVALID = 1'b1;
          beat_q.push_back(b);
          pend = 1'b0;
        end
      end else if (ARVALID) begin
        if (!ar_seen) begin
          ar_seen  = 1'b1;
          ar_cnt   = 0;
          hold_cur = (plan_q.size() > 0) ? plan_q[0].hold : $urandom_range(0, 2);
        end
        if (ar_cnt >= hold_cur) begin
          ARREADY = 1'b1;
          pend    = 1'b1;
          ar_seen = 1'b0;
          r_delay = $urandom_range(0, 2);
          read_count++;
        end else begin
          ar_cnt++;
        end
      end
    end
  end

  // Monitor: samples late in the low phase, when every handshake for the next edge is settled.
  initial begin : monitor
    int          cyc = 0;
    int          last_r_cyc = -100;
    bit          prev_ar_wait = 1'b0;
    bit          prev_arvalid = 1'b0;
    bit          outstanding = 1'b0;
    bit          have_last = 1'b0;
    logic [31:0] last_word = 32'h0;
    int          exp_err = 0;
    int          exp_stuck = 0;
    beat_t       b;
    logic [31:0] w;
    forever begin
      @(negedge ACLK);
      #3;
      cyc++;
      if (ARESET) begin
        exp_q.delete();
        beat_q.delete();
        have_last    = 1'b0;
        last_word    = 32'h0;
        exp_err      = 0;
        exp_stuck    = 0;
        outstanding  = 1'b0;
        prev_ar_wait = 1'b0;
        prev_arvalid = 1'b0;
        last_r_cyc   = -100;
      end else begin
        check("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
        check("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
        check("err_count", 32'(err_count), 32'(exp_err));
        check("stuck_count", 32'(stuck_count), 32'(exp_stuck));
        if (prev_ar_wait) check("arvalid_held", 32'(ARVALID), 32'd1);
        if (ARVALID) begin
          check("araddr", ARADDR, 32'h6400_0000);
          check("arid", 32'(ARID), 32'h0010);
          check("ar_len_size_burst", 32'({ARLEN, ARSIZE, ARBURST}), 32'({4'h0, 3'b010, 2'b01}));
          if (!prev_arvalid) check("ar_gap_ok", 32'(cyc - last_r_cyc >= 2), 32'd1);
        end
        prev_ar_wait = ARVALID && !ARREADY;
        prev_arvalid = ARVALID;
        if (ARVALID && ARREADY) begin
          check("single_outstanding", 32'(outstanding), 32'd0);
          outstanding = 1'b1;
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("pop_expected", 32'd0, 32'd1);
          end else begin
            w = exp_q.pop_front();
            check("m_data", m_data, w);
          end
        end
        if (RVALID && RREADY) begin
          outstanding = 1'b0;
          last_r_cyc  = cyc;
          if (beat_q.size() == 0) begin
            check("beat_known", 32'd0, 32'd1);
          end else begin
            b = beat_q.pop_front();
            if (b.resp == 2'b00 && b.id == 16'h0010 && b.last) begin
              if (have_last && b.data == last_word) exp_stuck = (exp_stuck < 65535) ? exp_stuck + 1 : 65535;
              have_last = 1'b1;
              last_word = b.data;
              exp_q.push_back(b.data);
            end else begin
              exp_err = (exp_err < 65535) ? exp_err + 1 : 65535;
            end
          end
        end
      end
    end
  end

  task automatic plan(input logic [31:0] data, input logic [1:0] resp, input logic [15:0] id, input int hold);
    beat_t b;
    b.data = data;
    b.resp = resp;
    b.id   = id;
    b.last = 1'b1;
    b.hold = hold;
    plan_q.push_back(b);
  endtask

  initial begin : main
    int  rc0;
    int  waited;
    repeat (3) @(negedge ACLK);
    #3;
    check("rst_arvalid", 32'(ARVALID), 32'd0);
    check("rst_rready", 32'(RREADY), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_stuck_count", 32'(stuck_count), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0;

    // Fill with no consumer: exactly FIFO_DEPTH reads, then idle.
    enable = 1'b1;
    repeat (60) @(negedge ACLK);
    #3;
    check("fill_read_count", 32'(read_count), 32'd4);
    check("fill_level", 32'(fifo_level), 32'd4);
    check("fill_arvalid_idle", 32'(ARVALID), 32'd0);

    @(negedge ACLK);
    enable  = 1'b0;
    m_ready = 1'b1;
    repeat (10) @(negedge ACLK);
    m_ready = 1'b0;
    #3;
    check("drain_level", 32'(fifo_level), 32'd0);

    // Directed beats: long AR stall, SLVERR, wrong RID, then a repeated word.
    plan(32'h1234_5678, 2'b10, 16'h0010, 5);
    plan(32'h2345_6789, 2'b00, 16'h0011, 0);
    plan(32'hDEAD_BEEF, 2'b00, 16'h0010, 0);
    plan(32'hDEAD_BEEF, 2'b00, 16'h0010, 0);
    @(negedge ACLK);
    enable = 1'b1;
    repeat (100) @(negedge ACLK);
    #3;
    check("dir_read_count", 32'(read_count), 32'd10);
    check("dir_err_count", 32'(err_count), 32'd2);
    check("dir_stuck_count", 32'(stuck_count), 32'd1);
    check("dir_level", 32'(fifo_level), 32'd4);
    check("dir_head_word", m_data, 32'hDEAD_BEEF);

    // Random traffic with occasional bad beats, random consumer and enable.
    rand_err = 1'b1;
    repeat (1500) begin
      @(negedge ACLK);
      m_ready = 1'($urandom_range(0, 1));
      enable  = ($urandom_range(0, 7) != 0);
    end

    // Reset while a read is waiting for its data.
    @(negedge ACLK);
    enable  = 1'b1;
    m_ready = 1'b1;
    waited  = 0;
    while (!RREADY && waited < 50) begin
      @(negedge ACLK);
      waited++;
    end
    check("reach_data_state", 32'(RREADY), 32'd1);
    #2;
    ARESET = 1'b1;
    #1;
    check("arst_arvalid", 32'(ARVALID), 32'd0);
    check("arst_rready", 32'(RREADY), 32'd0);
    check("arst_m_valid", 32'(m_valid), 32'd0);
    check("arst_err_count", 32'(err_count), 32'd0);
    check("arst_stuck_count", 32'(stuck_count), 32'd0);
    check("arst_fifo_level", 32'(fifo_level), 32'd0);
    rand_err = 1'b0;
    m_ready  = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    rc0 = read_count;
    repeat (60) @(negedge ACLK);
    #3;
    check("restart_reads", 32'(read_count - rc0), 32'd4);
    check("restart_level", 32'(fifo_level), 32'd4);
    check("restart_err_count", 32'(err_count), 32'd0);

    @(negedge ACLK);
    enable  = 1'b0;
    m_ready = 1'b1;
    repeat (10) @(negedge ACLK);
    #3;
    check("final_level", 32'(fifo_level), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
